shift_add_mult_seq: RTL
=======================

Name: shift_add_mult_seq

Overview:
Sequential unsigned shift-add multiplier controller that iterates a single multiplier_layer instance once per clock, instead of chaining `bits` layers combinationally. It sits directly upstream of multiplier_layer in the MLP datapath. It latches operands on a start/ready handshake, drives the layer's last/B/A_bit inputs each cycle, and collects out_bit and result back into registers. The full 2*bits product is presented with a one-cycle done pulse.

Parameters:
bits, 8, operand width. Product is 2*bits wide. Legal range is bits >= 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only while ready=1
a  input  bits  multiplier operand; bits are consumed LSB first as A_bit
b  input  bits  multiplicand operand; applied to the layer's B input
ready  output  1  high in IDLE; the block accepts start only when ready=1
done  output  1  one-cycle pulse; product is valid from this cycle on
product  output  2*bits  {acc, a_sr} at completion; held until the next completion

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state=IDLE, ready=1, done=0, product=0.
  - acc=0, a_sr=0, b_reg=0, count=0.
- Reset mid-operation:
  - Aborts the multiply immediately.
  - No done pulse is produced; product returns to 0.
- Internal registers: acc[bits], a_sr[bits], b_reg[bits], count[$clog2(bits+1)].
- One multiplier_layer instance, wired as:
  - last = acc
  - B = b_reg
  - A_bit = a_sr[0]
- FSM states:
  - IDLE:
    - ready=1.
    - On start=1 at edge E0: b_reg<=b, a_sr<=a, acc<=0, count<=0; go to RUN.
  - RUN:
    - ready=0.
    - Each edge: acc<=layer.result; a_sr<={layer.out_bit, a_sr[bits-1:1]}; count<=count+1.
    - When count==bits-1 at an edge, that edge performs the final iteration and the state goes to DONE.
  - DONE:
    - done=1 and ready=0 for exactly one cycle.
    - product = {acc, a_sr} is registered on the edge that enters DONE, so it is valid while done=1.
    - The next edge returns to IDLE.
- Latency:
  - start accepted at E0; iterations occur at E1..E_bits; done is high in the cycle following E_bits.
  - start-to-done is bits+1 edges; one multiply costs bits+2 cycles including the return to IDLE.
  - Back-to-back: start held high re-issues on the IDLE cycle after DONE.
- Ignored inputs:
  - start while in RUN or DONE is ignored; no queueing.
  - a and b are don't-care outside the accepting edge; changes during RUN do not affect the result.
- Arithmetic:
  - Unsigned: product = a*b exactly, with no overflow for any bits-wide inputs.
  - The carry into acc's MSB comes from the layer's Cout.
- Hold rules:
  - product changes only on the edge entering DONE.
  - done is never high for 2 consecutive cycles.
- count never exceeds bits-1 in RUN and is not used in IDLE/DONE.

Test Plan:
- bits=8, a=13, b=11, pulse start -> ready drops next cycle; done high exactly 9 edges after start edge; product=143; ready back high the cycle after done.
- bits=8, a=255, b=255 -> product=65025 (0xFE01), verifying the carry path into the MSB of acc.
- bits=8, a=0, b=200, then a=200, b=0, then a=1, b=200 -> products 0, 0, 200; each run has the same 9-edge latency.
- Start a=7, b=9; change a/b and pulse start again 3 cycles later (in RUN) -> second start ignored; single done pulse; product=63; no second done pulse.
- Start a=100, b=100; drop rst_n for 1 cycle at iteration 4 -> ready=1, product=0, no done pulse. A new start with a=3, b=5 after release -> product=15.
- Start held high continuously with a=6, b=7 -> done pulses every 10 cycles; product=42 each time; done never high for 2 consecutive cycles.

Source files
------------

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier_layer reused once per clock,
// with a start/ready handshake and a one-cycle done pulse carrying the 2*bits product.

module multiplier_layer #(
  parameter int bits = 8
) (
  input  logic [bits-1:0] last,
  input  logic [bits-1:0] b,
  input  logic            a_bit,
  output logic [bits-1:0] result,
  output logic            out_bit
);

  logic [bits-1:0] addend_s;
  logic [bits-1:0] sum_s;
  logic [bits:0]   carry_s;

  // Ripple-carry add of the gated multiplicand onto the running partial product
  always_comb begin
    addend_s = b & {bits{a_bit}};
    sum_s    = '0;
    carry_s  = '0;
    for (int i = 0; i < bits; i++) begin
      sum_s[i]       = last[i] ^ addend_s[i] ^ carry_s[i];
      carry_s[i + 1] = (last[i] & addend_s[i]) | (carry_s[i] & (last[i] ^ addend_s[i]));
    end
  end

  // Cout becomes the new MSB; the retired LSB leaves through out_bit
  assign result  = {carry_s[bits], sum_s[bits-1:1]};
  assign out_bit = sum_s[0];

endmodule

module shift_add_mult_seq #(
  parameter int bits = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [bits-1:0]   a,
  input  logic [bits-1:0]   b,
  output logic              ready,
  output logic              done,
  output logic [2*bits-1:0] product
);

  localparam int CW = $clog2(bits + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(bits - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [bits-1:0]   acc_r;
  logic [bits-1:0]   a_sr_r;
  logic [bits-1:0]   b_reg_r;
  logic [CW-1:0]     count_r;
  logic              ready_r;
  logic              done_r;
  logic [2*bits-1:0] product_r;

  logic [bits-1:0]   layer_result_s;
  logic              layer_out_bit_s;

  multiplier_layer #(.bits(bits)) u_layer (
    .last    (acc_r),
    .b       (b_reg_r),
    .a_bit   (a_sr_r[0]),
    .result  (layer_result_s),
    .out_bit (layer_out_bit_s)
  );

  // Controller FSM: operand capture, one layer iteration per RUN cycle, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      a_sr_r    <= '0;
      b_reg_r   <= '0;
      count_r   <= '0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            b_reg_r <= b;
            a_sr_r  <= a;
            acc_r   <= '0;
            count_r <= '0;
            ready_r <= 1'b0;
            state_r <= RUN;
          end else begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r   <= layer_result_s;
          a_sr_r  <= {layer_out_bit_s, a_sr_r[bits-1:1]};
          count_r <= count_r + ONE_CNT;
          ready_r <= 1'b0;
          if (count_r == LAST_CNT) begin
            // Capture the product straight from the final iteration's layer outputs
            product_r <= {layer_result_s, layer_out_bit_s, a_sr_r[bits-1:1]};
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
